// File: rtl/add3_arbiter_if.sv
// ============================================================================
// Module   : add3_arbiter_if
// Purpose  : Request, shared-adder and response signals of add3_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface add3_arbiter_if;
    logic       req0_valid;
    logic       req1_valid;
    logic [2:0] req0_a;
    logic [2:0] req0_b;
    logic [2:0] req1_a;
    logic [2:0] req1_b;
    logic       req0_ready;
    logic       req1_ready;
    logic [2:0] add_a;
    logic [2:0] add_b;
    logic [2:0] add_sum;
    logic       add_cout;
    logic       rsp_valid;
    logic       rsp_id;
    logic [2:0] rsp_sum;
    logic       rsp_cout;
    logic       rsp_ready;

    // Arbiter side
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready,
        output add_a, add_b,
        input  add_sum, add_cout,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready
    );

    // Requesters and response consumer
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready
    );

    // The shared external 3-bit adder
    modport adder (
        input  add_a, add_b,
        output add_sum, add_cout
    );
endinterface

`default_nettype wire

// File: rtl/add3_arbiter.sv
// ============================================================================
// Module   : add3_arbiter
// Purpose  : Two-requester arbiter sharing one external 3-bit adder, with a
//            registered response port and a saturating carry-out counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add3_arbiter #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    add3_arbiter_if.slave         bus,
    output logic [CNT_W-1:0]      ovf_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_OVF_MAX = '1;

    state_t           r_state;
    logic [2:0]       r_op_a;
    logic [2:0]       r_op_b;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [2:0]       r_rsp_sum;
    logic             r_rsp_cout;
    logic [CNT_W-1:0] r_ovf_count;
    logic             r_last_srv;

    logic             w_grant;
    logic             w_idle;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept;

    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        w_grant  = 1'b0;
        w_idle   = (r_state == S_IDLE);
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last_srv;
        end else begin
            w_grant = bus.req1_valid;
        end
        w_ready0 = ~rst && w_idle && bus.req0_valid && ~w_grant;
        w_ready1 = ~rst && w_idle && bus.req1_valid &&  w_grant;
        w_accept = w_ready0 | w_ready1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op_a      <= 3'd0;
            r_op_b      <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_sum   <= 3'd0;
            r_rsp_cout  <= 1'b0;
            r_ovf_count <= '0;
            r_last_srv  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a     <= w_grant ? bus.req1_a : bus.req0_a;
                        r_op_b     <= w_grant ? bus.req1_b : bus.req0_b;
                        r_rsp_id   <= w_grant;
                        r_last_srv <= w_grant;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_rsp_sum   <= bus.add_sum;
                    r_rsp_cout  <= bus.add_cout;
                    r_rsp_valid <= 1'b1;
                    if (bus.add_cout && (r_ovf_count != c_OVF_MAX)) begin
                        r_ovf_count <= r_ovf_count + 1'b1;
                    end
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The adder only ever sees latched operands, so late requester changes are harmless.
    assign bus.add_a      = r_op_a;
    assign bus.add_b      = r_op_b;
    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_sum    = r_rsp_sum;
    assign bus.rsp_cout   = r_rsp_cout;
    assign ovf_count      = r_ovf_count;

endmodule

`default_nettype wire

// File: tb/tb_add3_arbiter.sv
// ============================================================================
// Module   : tb_add3_arbiter
// Purpose  : Self-checking bench for add3_arbiter (vectors, corner sequences,
//            randomized traffic against a transaction-level reference).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add3_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ovf;
    logic [1:0] ovf2;
    int         total = 0;
    int         bad   = 0;

    add3_arbiter_if bus ();
    add3_arbiter_if bus2 ();

    add3_arbiter #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus), .ovf_count(ovf));
    add3_arbiter #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .ovf_count(ovf2));

    // External adders
    assign {bus.add_cout, bus.add_sum}   = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    assign {bus2.add_cout, bus2.add_sum} = {1'b0, bus2.add_a} + {1'b0, bus2.add_b};

    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [2:0] a0;
        logic [2:0] b0;
        logic       v1;
        logic [2:0] a1;
        logic [2:0] b1;
        logic       id;
        logic [2:0] sum;
        logic       cout;
        int         ovf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = 3'd0; bus.req0_b = 3'd0; bus.req1_a = 3'd0; bus.req1_b = 3'd0;
        bus.rsp_ready = 1'b0;
    endtask

    // Valids are held high during reset to show that nothing is accepted.
    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        cyc();
        cyc();
        chk("rst_rdy0", bus.req0_ready, 0);
        chk("rst_rdy1", bus.req1_ready, 0);
        rst = 1'b0;
        idle_inputs();
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        bus.req0_valid = v.v0; bus.req0_a = v.a0; bus.req0_b = v.b0;
        bus.req1_valid = v.v1; bus.req1_a = v.a1; bus.req1_b = v.b1;
        bus.rsp_ready  = 1'b1;
        #1;
        chk("txn_grant", {bus.req1_ready, bus.req0_ready}, v.id ? 2 : 1);
        cyc();
        bus.req0_a = ~v.a0; bus.req0_b = ~v.b0; bus.req1_a = ~v.a1; bus.req1_b = ~v.b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        #1;
        chk("txn_issue_vld", bus.rsp_valid, 0);
        chk("txn_add_a", bus.add_a, v.id ? v.a1 : v.a0);
        chk("txn_add_b", bus.add_b, v.id ? v.b1 : v.b0);
        cyc();
        chk("txn_rsp_vld", bus.rsp_valid, 1);
        chk("txn_rsp_id", bus.rsp_id, v.id);
        chk("txn_rsp_sum", bus.rsp_sum, v.sum);
        chk("txn_rsp_cout", bus.rsp_cout, v.cout);
        chk("txn_ovf", ovf, v.ovf);
        cyc();
        chk("txn_done_vld", bus.rsp_valid, 0);
    endtask

    int          q_id[$];
    int          q_sum[$];
    int          q_cout[$];
    // transaction-level reference state
    int          m_age;
    int          m_last;
    int          m_id;
    int          m_sum;
    int          m_cout;
    int          m_ovf;
    int          exp2[5];
    bit          found;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        bus2.req0_valid = 1'b0; bus2.req1_valid = 1'b0;
        bus2.req0_a = 3'd0; bus2.req0_b = 3'd0; bus2.req1_a = 3'd0; bus2.req1_b = 3'd0;
        bus2.rsp_ready = 1'b1;

        tbl[0] = '{1'b1, 3'd6, 3'd1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd7, 1'b0, 0};
        tbl[1] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd5, 3'd4, 1'b1, 3'd1, 1'b1, 1};
        tbl[2] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 3'd4, 1'b1, 3'd2, 1'b1, 2};
        tbl[3] = '{1'b1, 3'd2, 3'd3, 1'b1, 3'd6, 3'd4, 1'b0, 3'd5, 1'b0, 2};
        tbl[4] = '{1'b1, 3'd2, 3'd3, 1'b1, 3'd6, 3'd4, 1'b1, 3'd2, 1'b1, 3};
        tbl[5] = '{1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0, 3'd6, 1'b0, 3};
        tbl[6] = '{1'b1, 3'd7, 3'd1, 1'b1, 3'd0, 3'd1, 1'b1, 3'd1, 1'b0, 3};
        tbl[7] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 3'd7, 1'b1, 3'd6, 1'b1, 4};
        tbl[8] = '{1'b1, 3'd4, 3'd4, 1'b1, 3'd1, 3'd1, 1'b0, 3'd0, 1'b1, 5};

        // Reset values
        do_reset();
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_sum", bus.rsp_sum, 0);
        chk("rst_rsp_cout", bus.rsp_cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_add_a", bus.add_a, 0);
        chk("rst_add_b", bus.add_b, 0);

        // Vector table
        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Tie straight after reset: req0 first, then req1, never both ready
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 3'd2; bus.req0_b = 3'd3;
        bus.req1_valid = 1'b1; bus.req1_a = 3'd6; bus.req1_b = 3'd4;
        bus.rsp_ready  = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk("tie_excl", bus.req0_ready & bus.req1_ready, 0);
            if (bus.rsp_valid) begin
                q_id.push_back(int'(bus.rsp_id));
                q_sum.push_back(int'(bus.rsp_sum));
                q_cout.push_back(int'(bus.rsp_cout));
            end
            cyc();
        end
        chk("tie_nresp", q_id.size(), 2);
        if (q_id.size() >= 2) begin
            chk("tie_id0", q_id[0], 0);
            chk("tie_sum0", q_sum[0], 5);
            chk("tie_cout0", q_cout[0], 0);
            chk("tie_id1", q_id[1], 1);
            chk("tie_sum1", q_sum[1], 2);
            chk("tie_cout1", q_cout[1], 1);
        end
        idle_inputs();
        bus.rsp_ready = 1'b1;
        cyc(); cyc(); cyc();

        // Backpressure: 5 stalled cycles in RESP with both requesters waiting
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 3'd1; bus.req0_b = 3'd2;
        bus.req1_valid = 1'b1; bus.req1_a = 3'd3; bus.req1_b = 3'd3;
        bus.rsp_ready  = 1'b0;
        #1;
        chk("bp_grant0", bus.req0_ready, 1);
        cyc();
        chk("bp_issue_rdy", {bus.req1_ready, bus.req0_ready}, 0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", bus.rsp_valid, 1);
            chk("bp_id", bus.rsp_id, 0);
            chk("bp_sum", bus.rsp_sum, 3);
            chk("bp_cout", bus.rsp_cout, 0);
            chk("bp_rdy", {bus.req1_ready, bus.req0_ready}, 0);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_vld", bus.rsp_valid, 1);
        cyc();
        chk("bp_after_vld", bus.rsp_valid, 0);
        chk("bp_next_grant1", {bus.req1_ready, bus.req0_ready}, 2);
        idle_inputs();
        cyc();

        // Reset during ISSUE, then during RESP
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_a = 3'd7; bus.req1_b = 3'd7;
        bus.rsp_ready  = 1'b1;
        #1;
        chk("rm_accept1", bus.req1_ready, 1);
        cyc();
        bus.req1_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rm_issue_vld", bus.rsp_valid, 0);
        chk("rm_issue_ovf", ovf, 0);
        bus.req1_valid = 1'b1;
        #1;
        cyc();
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        cyc();
        chk("rm_resp_vld", bus.rsp_valid, 1);
        chk("rm_resp_ovf", ovf, 1);
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 3'd1; bus.req0_b = 3'd1;
        bus.req1_valid = 1'b1;
        #1;
        chk("rm_rst_rdy", {bus.req1_ready, bus.req0_ready}, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rm_resp_vld_clr", bus.rsp_valid, 0);
        chk("rm_resp_ovf_clr", ovf, 0);
        chk("rm_tie_grant0", {bus.req1_ready, bus.req0_ready}, 1);
        idle_inputs();
        cyc();

        // Randomized traffic against a transaction-level reference
        do_reset();
        m_age = -1; m_last = 1; m_ovf = 0; m_id = 0; m_sum = 0; m_cout = 0;
        for (int n = 0; n < 600; n++) begin
            int v0, v1, a0, b0, a1, b1, g, tot;
            v0 = int'($urandom_range(0, 9) < 6);
            v1 = int'($urandom_range(0, 9) < 6);
            a0 = int'($urandom_range(0, 7)); b0 = int'($urandom_range(0, 7));
            a1 = int'($urandom_range(0, 7)); b1 = int'($urandom_range(0, 7));
            bus.req0_valid = v0[0]; bus.req0_a = a0[2:0]; bus.req0_b = b0[2:0];
            bus.req1_valid = v1[0]; bus.req1_a = a1[2:0]; bus.req1_b = b1[2:0];
            bus.rsp_ready  = ($urandom_range(0, 1) == 1);
            #1;
            chk("rnd_ovf", ovf, m_ovf);
            if (m_age < 0) begin
                if (v0 == 1 && v1 == 1) g = 1 - m_last;
                else if (v1 == 1) g = 1;
                else g = 0;
                chk("rnd_rdy0", bus.req0_ready, (v0 == 1 && g == 0) ? 1 : 0);
                chk("rnd_rdy1", bus.req1_ready, (v1 == 1 && g == 1) ? 1 : 0);
                chk("rnd_idle_vld", bus.rsp_valid, 0);
                if (v0 == 1 || v1 == 1) begin
                    tot    = (g == 1) ? (a1 + b1) : (a0 + b0);
                    m_id   = g;
                    m_sum  = tot % 8;
                    m_cout = tot / 8;
                    m_last = g;
                    m_age  = 1;
                end
            end else if (m_age == 1) begin
                chk("rnd_issue_vld", bus.rsp_valid, 0);
                chk("rnd_issue_rdy", {bus.req1_ready, bus.req0_ready}, 0);
                m_ovf = (m_ovf + m_cout > 255) ? 255 : m_ovf + m_cout;
                m_age = 2;
            end else begin
                chk("rnd_rsp_vld", bus.rsp_valid, 1);
                chk("rnd_rsp_id", bus.rsp_id, m_id);
                chk("rnd_rsp_sum", bus.rsp_sum, m_sum);
                chk("rnd_rsp_cout", bus.rsp_cout, m_cout);
                chk("rnd_rsp_rdy", {bus.req1_ready, bus.req0_ready}, 0);
                if (bus.rsp_ready) m_age = -1;
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        bus.rsp_ready = 1'b1;
        cyc(); cyc(); cyc();

        // Saturation on the 2-bit counter instance
        do_reset();
        exp2[0] = 1; exp2[1] = 2; exp2[2] = 3; exp2[3] = 3; exp2[4] = 3;
        bus2.req0_a = 3'd7; bus2.req0_b = 3'd7; bus2.rsp_ready = 1'b1;
        bus2.req0_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (!found) begin
                    if (bus2.rsp_valid) begin
                        chk("sat_ovf", ovf2, exp2[k]);
                        found = 1'b1;
                    end
                    cyc();
                end
            end
            if (!found) chk("sat_timeout", 0, 1);
        end
        bus2.req0_valid = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
